// File: rtl/lsu_stride_agen.sv
// Constant-stride load/store address generator for the VMU scratchpad port.
// Issues one SPM beat per cycle under back-pressure; store beats are delayed WR_DELAY cycles.
module lsu_stride_agen #(
   parameter int unsigned LSU_OP_WIDTH = 2,
   parameter int unsigned SCALAR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH    = 16,
   parameter int unsigned STRIDE_WIDTH = 16,
   parameter int unsigned WR_DELAY     = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_cmd_vld,
   output logic                    o_cmd_rdy,
   input  logic [LSU_OP_WIDTH-1:0] i_cmd_op,
   input  logic [SCALAR_WIDTH-1:0] i_cmd_base,
   input  logic [STRIDE_WIDTH-1:0] i_cmd_stride,
   input  logic [CNT_WIDTH-1:0]    i_cmd_len,
   input  logic                    i_spm_stall,
   output logic                    o_vmu_spm_rden,
   output logic [SCALAR_WIDTH-1:0] o_vmu_spm_rdaddr,
   output logic                    o_vmu_spm_wren,
   output logic [SCALAR_WIDTH-1:0] o_vmu_spm_wraddr,
   output logic [CNT_WIDTH-1:0]    o_beat_idx,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam logic [LSU_OP_WIDTH-1:0] OP_LOAD  = LSU_OP_WIDTH'(1);
   localparam logic [LSU_OP_WIDTH-1:0] OP_STORE = LSU_OP_WIDTH'(2);
   localparam int unsigned DW = (WR_DELAY < 2) ? 1 : $clog2(WR_DELAY);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

   state_t                  state_q, state_d;
   logic [LSU_OP_WIDTH-1:0] op_q;
   logic [SCALAR_WIDTH-1:0] addr_q;
   logic [SCALAR_WIDTH-1:0] stride_q;
   logic [SCALAR_WIDTH-1:0] rdaddr_q;
   logic [CNT_WIDTH-1:0]    len_q;
   logic [CNT_WIDTH-1:0]    idx_q;
   logic [DW-1:0]           drain_q;

   logic                    accept;
   logic                    cmd_active;
   logic                    iss_en;
   logic                    consume;
   logic                    last_beat;
   logic                    is_load;
   logic                    is_store;
   logic [SCALAR_WIDTH-1:0] stride_ext;
   logic [SCALAR_WIDTH-1:0] next_addr;
   logic                    st_beat;
   logic [SCALAR_WIDTH-1:0] st_addr;

   assign stride_ext = SCALAR_WIDTH'($signed(i_cmd_stride));
   assign accept     = i_cmd_vld && (state_q == S_IDLE);
   assign cmd_active = ((i_cmd_op == OP_LOAD) || (i_cmd_op == OP_STORE)) && (i_cmd_len != '0);
   assign is_load    = (op_q == OP_LOAD);
   assign is_store   = (op_q == OP_STORE);
   assign iss_en     = (state_q == S_RUN);
   assign consume    = iss_en && !i_spm_stall;
   assign last_beat  = (idx_q == (len_q - CNT_WIDTH'(1)));
   assign next_addr  = addr_q + stride_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = cmd_active ? S_RUN : S_FIN;
         S_RUN:   if (consume && last_beat)
                     state_d = (is_store && (WR_DELAY > 0)) ? S_DRAIN : S_FIN;
         S_DRAIN: if (drain_q == '0) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The accumulator does not advance past the last beat so rdaddr/idx hold it afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q     <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         rdaddr_q <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         drain_q  <= '0;
      end else begin
         if (accept) begin
            op_q     <= i_cmd_op;
            stride_q <= stride_ext;
            len_q    <= i_cmd_len;
            if (cmd_active) begin
               addr_q <= i_cmd_base;
               idx_q  <= '0;
               if (i_cmd_op == OP_LOAD) rdaddr_q <= i_cmd_base;
            end
         end
         if (consume && !last_beat) begin
            addr_q <= next_addr;
            idx_q  <= idx_q + CNT_WIDTH'(1);
            if (is_load) rdaddr_q <= next_addr;
         end
         if ((state_q == S_RUN) && (state_d == S_DRAIN))
            drain_q <= DW'(WR_DELAY - 1);
         else if ((state_q == S_DRAIN) && (drain_q != '0))
            drain_q <= drain_q - DW'(1);
      end
   end

   assign st_beat = consume && is_store;
   assign st_addr = st_beat ? addr_q : '0;

   generate
      if (WR_DELAY == 0) begin : g_wr_comb
         assign o_vmu_spm_wren   = st_beat;
         assign o_vmu_spm_wraddr = st_addr;
      end else begin : g_wr_pipe
         logic [WR_DELAY-1:0]     wen_pipe;
         logic [SCALAR_WIDTH-1:0] wadr_pipe [WR_DELAY];

         // Free-running: stalls insert empty slots rather than freezing the line.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               wen_pipe <= '0;
               for (int unsigned i = 0; i < WR_DELAY; i++) wadr_pipe[i] <= '0;
            end else begin
               wen_pipe[0]  <= st_beat;
               wadr_pipe[0] <= st_addr;
               for (int unsigned i = 1; i < WR_DELAY; i++) begin
                  wen_pipe[i]  <= wen_pipe[i-1];
                  wadr_pipe[i] <= wadr_pipe[i-1];
               end
            end
         end

         assign o_vmu_spm_wren   = wen_pipe[WR_DELAY-1];
         assign o_vmu_spm_wraddr = wadr_pipe[WR_DELAY-1];
      end
   endgenerate

   assign o_cmd_rdy        = (state_q == S_IDLE);
   assign o_busy           = (state_q != S_IDLE);
   assign o_done           = (state_q == S_FIN);
   assign o_vmu_spm_rden   = iss_en && is_load;
   assign o_vmu_spm_rdaddr = rdaddr_q;
   assign o_beat_idx       = idx_q;

endmodule

// File: tb/tb_lsu_stride_agen.sv
// Directed self-checking bench for lsu_stride_agen (WR_DELAY = 3).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_lsu_stride_agen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_cmd_vld = 1'b0;
   logic        o_cmd_rdy;
   logic [1:0]  i_cmd_op = '0;
   logic [31:0] i_cmd_base = '0;
   logic [15:0] i_cmd_stride = '0;
   logic [15:0] i_cmd_len = '0;
   logic        i_spm_stall = 1'b0;
   logic        o_vmu_spm_rden;
   logic [31:0] o_vmu_spm_rdaddr;
   logic        o_vmu_spm_wren;
   logic [31:0] o_vmu_spm_wraddr;
   logic [15:0] o_beat_idx;
   logic        o_busy;
   logic        o_done;

   int n_cmp = 0;
   int n_err = 0;

   lsu_stride_agen #(
      .LSU_OP_WIDTH(2),
      .SCALAR_WIDTH(32),
      .CNT_WIDTH(16),
      .STRIDE_WIDTH(16),
      .WR_DELAY(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_cmd_vld(i_cmd_vld),
      .o_cmd_rdy(o_cmd_rdy),
      .i_cmd_op(i_cmd_op),
      .i_cmd_base(i_cmd_base),
      .i_cmd_stride(i_cmd_stride),
      .i_cmd_len(i_cmd_len),
      .i_spm_stall(i_spm_stall),
      .o_vmu_spm_rden(o_vmu_spm_rden),
      .o_vmu_spm_rdaddr(o_vmu_spm_rdaddr),
      .o_vmu_spm_wren(o_vmu_spm_wren),
      .o_vmu_spm_wraddr(o_vmu_spm_wraddr),
      .o_beat_idx(o_beat_idx),
      .o_busy(o_busy),
      .o_done(o_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a command for one edge; on return the bench is in cycle T+1.
   task automatic send(input logic [1:0] op, input logic [31:0] base,
                       input logic [15:0] stride, input logic [15:0] len);
      i_cmd_vld    = 1'b1;
      i_cmd_op     = op;
      i_cmd_base   = base;
      i_cmd_stride = stride;
      i_cmd_len    = len;
      tick();
      i_cmd_vld = 1'b0;
      i_cmd_op  = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      n_cmp++; if (o_cmd_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", o_cmd_rdy); end
      n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", o_done); end
      n_cmp++; if (o_vmu_spm_rden !== 1'b0 || o_vmu_spm_wren !== 1'b0) begin n_err++; $display("FAIL reset_en: got rden=%b wren=%b want 0/0", o_vmu_spm_rden, o_vmu_spm_wren); end
      n_cmp++; if (o_vmu_spm_rdaddr !== 32'h0 || o_vmu_spm_wraddr !== 32'h0 || o_beat_idx !== 16'h0) begin n_err++; $display("FAIL reset_vals: got rdaddr=%h wraddr=%h idx=%h want 0", o_vmu_spm_rdaddr, o_vmu_spm_wraddr, o_beat_idx); end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (o_cmd_rdy !== 1'b1 || o_busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got rdy=%b busy=%b want 1/0", o_cmd_rdy, o_busy); end
   endtask

   task automatic test_unit_load();
      logic [31:0] ea;
      logic [15:0] ei;
      send(2'b01, 32'h100, 16'd1, 16'd4);
      for (int c = 1; c <= 6; c++) begin
         ea = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h103;
         ei = (c <= 4) ? 16'(c - 1) : 16'd3;
         n_cmp++; if (o_vmu_spm_rden !== (c <= 4)) begin n_err++; $display("FAIL uload_rden c%0d: got %b want %b", c, o_vmu_spm_rden, (c <= 4)); end
         n_cmp++; if (o_vmu_spm_rdaddr !== ea) begin n_err++; $display("FAIL uload_rdaddr c%0d: got %h want %h", c, o_vmu_spm_rdaddr, ea); end
         n_cmp++; if (o_beat_idx !== ei) begin n_err++; $display("FAIL uload_idx c%0d: got %0d want %0d", c, o_beat_idx, ei); end
         n_cmp++; if (o_done !== (c == 5)) begin n_err++; $display("FAIL uload_done c%0d: got %b want %b", c, o_done, (c == 5)); end
         n_cmp++; if (o_vmu_spm_wren !== 1'b0) begin n_err++; $display("FAIL uload_wren c%0d: got %b want 0", c, o_vmu_spm_wren); end
         n_cmp++; if (o_cmd_rdy !== (c == 6)) begin n_err++; $display("FAIL uload_rdy c%0d: got %b want %b", c, o_cmd_rdy, (c == 6)); end
         if (c < 6) tick();
      end
   endtask

   task automatic test_neg_store(input string tag);
      logic [31:0] ew;
      send(2'b10, 32'h10, 16'hFFFC, 16'd3);
      for (int c = 1; c <= 8; c++) begin
         case (c)
            4:       ew = 32'h10;
            5:       ew = 32'h0C;
            6:       ew = 32'h08;
            default: ew = 32'h0;
         endcase
         n_cmp++; if (o_vmu_spm_wren !== (c >= 4 && c <= 6)) begin n_err++; $display("FAIL %s_wren c%0d: got %b want %b", tag, c, o_vmu_spm_wren, (c >= 4 && c <= 6)); end
         n_cmp++; if (o_vmu_spm_wraddr !== ew) begin n_err++; $display("FAIL %s_wraddr c%0d: got %h want %h", tag, c, o_vmu_spm_wraddr, ew); end
         n_cmp++; if (o_vmu_spm_rden !== 1'b0) begin n_err++; $display("FAIL %s_rden c%0d: got %b want 0", tag, c, o_vmu_spm_rden); end
         n_cmp++; if (o_done !== (c == 7)) begin n_err++; $display("FAIL %s_done c%0d: got %b want %b", tag, c, o_done, (c == 7)); end
         n_cmp++; if (o_busy !== (c <= 7)) begin n_err++; $display("FAIL %s_busy c%0d: got %b want %b", tag, c, o_busy, (c <= 7)); end
         if (c < 8) tick();
      end
   endtask

   task automatic test_stall_load();
      logic [31:0] ea [4] = '{32'd0, 32'd2, 32'd2, 32'd4};
      logic [15:0] ei [4] = '{16'd0, 16'd1, 16'd1, 16'd2};
      send(2'b01, 32'h0, 16'd2, 16'd3);
      for (int c = 1; c <= 5; c++) begin
         i_spm_stall = (c == 2);
         if (c <= 4) begin
            n_cmp++; if (o_vmu_spm_rden !== 1'b1) begin n_err++; $display("FAIL stall_rden c%0d: got %b want 1", c, o_vmu_spm_rden); end
            n_cmp++; if (o_vmu_spm_rdaddr !== ea[c-1]) begin n_err++; $display("FAIL stall_rdaddr c%0d: got %h want %h", c, o_vmu_spm_rdaddr, ea[c-1]); end
            n_cmp++; if (o_beat_idx !== ei[c-1]) begin n_err++; $display("FAIL stall_idx c%0d: got %0d want %0d", c, o_beat_idx, ei[c-1]); end
         end
         n_cmp++; if (o_done !== (c == 5)) begin n_err++; $display("FAIL stall_done c%0d: got %b want %b", c, o_done, (c == 5)); end
         tick();
      end
      i_spm_stall = 1'b0;
   endtask

   task automatic test_wrap();
      logic [31:0] ea [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
      send(2'b01, 32'hFFFF_FFFE, 16'd1, 16'd3);
      for (int c = 1; c <= 4; c++) begin
         if (c <= 3) begin
            n_cmp++; if (o_vmu_spm_rdaddr !== ea[c-1]) begin n_err++; $display("FAIL wrap_rdaddr c%0d: got %h want %h", c, o_vmu_spm_rdaddr, ea[c-1]); end
         end
         n_cmp++; if (o_done !== (c == 4)) begin n_err++; $display("FAIL wrap_done c%0d: got %b want %b", c, o_done, (c == 4)); end
         tick();
      end
   endtask

   task automatic test_degenerate();
      send(2'b01, 32'h40, 16'd1, 16'd0);
      n_cmp++; if (o_done !== 1'b1 || o_cmd_rdy !== 1'b0 || o_busy !== 1'b1) begin n_err++; $display("FAIL deg_len0_fin: got done=%b rdy=%b busy=%b want 1/0/1", o_done, o_cmd_rdy, o_busy); end
      n_cmp++; if (o_vmu_spm_rden !== 1'b0 || o_vmu_spm_wren !== 1'b0) begin n_err++; $display("FAIL deg_len0_en: got rden=%b wren=%b want 0/0", o_vmu_spm_rden, o_vmu_spm_wren); end
      tick();
      n_cmp++; if (o_done !== 1'b0 || o_cmd_rdy !== 1'b1) begin n_err++; $display("FAIL deg_len0_idle: got done=%b rdy=%b want 0/1", o_done, o_cmd_rdy); end
      // Back-to-back: accepted in the first cycle that rdy is high again.
      send(2'b00, 32'h80, 16'd1, 16'd5);
      n_cmp++; if (o_done !== 1'b1 || o_cmd_rdy !== 1'b0) begin n_err++; $display("FAIL deg_opnone_fin: got done=%b rdy=%b want 1/0", o_done, o_cmd_rdy); end
      n_cmp++; if (o_vmu_spm_rden !== 1'b0 || o_vmu_spm_wren !== 1'b0) begin n_err++; $display("FAIL deg_opnone_en: got rden=%b wren=%b want 0/0", o_vmu_spm_rden, o_vmu_spm_wren); end
      tick();
      n_cmp++; if (o_done !== 1'b0 || o_cmd_rdy !== 1'b1 || o_vmu_spm_rden !== 1'b0) begin n_err++; $display("FAIL deg_opnone_idle: got done=%b rdy=%b rden=%b want 0/1/0", o_done, o_cmd_rdy, o_vmu_spm_rden); end
   endtask

   task automatic test_reset_mid_store();
      send(2'b10, 32'h1000, 16'd4, 16'd8);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_cmp++; if (o_cmd_rdy !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctrl: got rdy=%b busy=%b done=%b want 1/0/0", o_cmd_rdy, o_busy, o_done); end
      n_cmp++; if (o_vmu_spm_wren !== 1'b0 || o_vmu_spm_rden !== 1'b0 || o_vmu_spm_wraddr !== 32'h0) begin n_err++; $display("FAIL rst_mid_en: got wren=%b rden=%b wraddr=%h want 0/0/0", o_vmu_spm_wren, o_vmu_spm_rden, o_vmu_spm_wraddr); end
      n_cmp++; if (o_beat_idx !== 16'h0) begin n_err++; $display("FAIL rst_mid_idx: got %0d want 0", o_beat_idx); end
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++; if (o_vmu_spm_wren !== 1'b0 || o_done !== 1'b0 || o_cmd_rdy !== 1'b1) begin n_err++; $display("FAIL rst_mid_quiet c%0d: got wren=%b done=%b rdy=%b want 0/0/1", c, o_vmu_spm_wren, o_done, o_cmd_rdy); end
      end
      test_neg_store("rst_store");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_unit_load();
      test_neg_store("nstore");
      test_stall_load();
      test_wrap();
      test_degenerate();
      test_reset_mid_store();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_stride_agen.md
Name: lsu_stride_agen

Overview:
Second-generation load/store address generator for the VMU scratchpad (SPM) port.
- Generalises the unit-stride LSU to signed constant-stride access.
- Accepts one command per valid/ready handshake.
- Issues one SPM beat per cycle with back-pressure from the SPM.
- Delays store enables and addresses by a parametrised write latency to align with VMU write data.
- Sits between the VMU sequencer and the SPM arbiter.

Parameters:
LSU_OP_WIDTH, 2, op encoding width (00 none, 01 load, 10 store, 11 reserved = none)
SCALAR_WIDTH, 32, SPM address width; address arithmetic is modulo 2^SCALAR_WIDTH
CNT_WIDTH, 16, beat-count / beat-index width
STRIDE_WIDTH, 16, signed stride width; sign-extended to SCALAR_WIDTH
WR_DELAY, 3, cycles from store-beat consumption to o_vmu_spm_wren; 0 is legal

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
i_cmd_vld  in  1  command valid
o_cmd_rdy  out  1  command ready; high only in IDLE
i_cmd_op  in  LSU_OP_WIDTH  load/store/none
i_cmd_base  in  SCALAR_WIDTH  address of beat 0
i_cmd_stride  in  STRIDE_WIDTH  signed address increment per beat
i_cmd_len  in  CNT_WIDTH  number of beats
i_spm_stall  in  1  SPM back-pressure; a beat is consumed when its enable is high and stall is low
o_vmu_spm_rden  out  1  read enable
o_vmu_spm_rdaddr  out  SCALAR_WIDTH  read address
o_vmu_spm_wren  out  1  write enable, delayed WR_DELAY cycles
o_vmu_spm_wraddr  out  SCALAR_WIDTH  write address, delayed with wren
o_beat_idx  out  CNT_WIDTH  index of the beat currently presented
o_busy  out  1  high whenever state != IDLE
o_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: synchronous, active-low. Every output is 0 except o_cmd_rdy (1 after reset). State returns to IDLE, the write delay line is cleared and the counters are cleared. Asserting reset mid-command aborts it; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - On vld&rdy at edge T, latch base, stride (sign-extended), len and op.
  - op=load/store with len>0 -> RUN.
  - op=none/reserved, or len=0 -> FIN, with no beats issued.
- RUN, issue stage (registered):
  - Beat k is presented with address = base + k*stride, formed by an accumulator (add on consume, no multiplier). The address wraps modulo 2^SCALAR_WIDTH.
  - o_beat_idx = k.
  - Beat 0 is visible in cycle T+1.
- Load: o_vmu_spm_rden=1 and o_vmu_spm_rdaddr = beat address.
- Store: an internal issue enable plays the same role; o_vmu_spm_rden stays 0.
- Stall: if i_spm_stall=1 while a beat is presented, the beat is held (same address, enable high, same idx) and is not consumed. Otherwise the next beat is presented on the following cycle.
- Last beat consumed:
  - Load -> FIN.
  - Store -> DRAIN if WR_DELAY>0, else FIN.
- Store write path:
  - Each consumed beat's {1, addr} enters a free-running WR_DELAY-stage shift line. Stall does not freeze this line; bubbles enter as enable 0.
  - Outputs are o_vmu_spm_wren and o_vmu_spm_wraddr.
  - WR_DELAY=0 means wren/wraddr are driven combinationally from consumed store beats.
- DRAIN: counts WR_DELAY cycles after the last store beat is consumed, then -> FIN.
- FIN: o_done=1 for exactly one cycle, o_busy=1, o_cmd_rdy=0; then -> IDLE.
- A new command can be accepted the cycle after o_done.
- When no beat is presented, enables are 0, rdaddr holds its last value, and o_beat_idx holds.
- o_vmu_spm_wraddr is 0 whenever the corresponding delay-line slot is empty.

Test Plan:
- Unit-stride load, base=0x100, stride=1, len=4, no stall, accept at T -> rden high T+1..T+4, rdaddr 0x100,0x101,0x102,0x103; done at T+5; wren never high.
- Negative-stride store, base=0x10, stride=-4, len=3, WR_DELAY=3 -> wren high T+4..T+6, wraddr 0x10,0x0C,0x08; done at T+7; rden never high.
- Stall mid-load, base=0, stride=2, len=3, stall high in cycle T+2 only -> rdaddr 0,2,2,4 on T+1..T+4; o_beat_idx 0,1,1,2; done at T+5.
- Wrap-around, SCALAR_WIDTH=32, base=0xFFFFFFFE, stride=1, len=3, load -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Degenerate commands, len=0 load, then op=00 len=5 -> no enables; done one cycle after each accept; rdy low only during FIN.
- Reset during store, WR_DELAY=3, rst_n low at T+3 of a len=8 store -> next cycle all enables 0, delay line empty, rdy=1, no done pulse; a fresh command afterwards behaves as in the negative-stride store scenario.
